fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Sequences instruction fetch for the RISC-V core: owns the PC and issues one request at a time to instruction memory. It waits for a variable-latency response and presents the fetched word to decode with a valid/ready handshake. It applies jump/branch redirects (branch taken when branch && zflag) at instruction acceptance. It raises a sticky fault on a memory timeout or a misaligned target.

Parameters:
XLEN, 32, PC and data width
RESET_PC, 32'h0000_0000, PC loaded on reset and on leaving IDLE
MAX_WAIT, 15, max cycles in WAIT before timeout fault (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
run  in  1  enable fetching
imem_req  out  1  one-cycle request pulse
imem_addr  out  XLEN  request address (= pc)
imem_valid  in  1  response valid; sampled only in WAIT
imem_rdata  in  32  response instruction word
instr_valid  out  1  fetched instruction available
instr  out  32  fetched instruction
pc_out  out  XLEN  PC of instr
dec_ready  in  1  decode accepts instr this cycle
jump  in  1  unconditional redirect to jump_target
jump_target  in  XLEN  absolute jump target
branch  in  1  conditional branch
zflag  in  1  ALU zero flag; branch taken when branch && zflag
br_target  in  XLEN  absolute branch target
fault  out  1  sticky fault
fault_cause  out  2  0 none, 1 timeout, 2 misaligned

Behaviour:
- Reset (async, active-high): state IDLE, pc=RESET_PC. Outputs reset to 0: imem_req, instr_valid, instr, fault, fault_cause. pc_out and imem_addr reset to RESET_PC. wait_cnt=0.
- States: IDLE, REQ, WAIT, HOLD, FAULT (encoded in fetch_pkg).
- IDLE: if run=1 -> REQ; otherwise remain in IDLE.
- REQ: imem_req=1 (decoded from state) and imem_addr=pc. Next state WAIT; wait_cnt cleared.
- WAIT:
  - imem_valid=1: latch instr=imem_rdata and pc_out=pc, go to HOLD. instr_valid=1 from the next cycle.
  - Otherwise wait_cnt increments. If wait_cnt==MAX_WAIT-1 and imem_valid=0, go to FAULT with cause=1.
  - imem_valid on the final permitted cycle wins over the timeout.
- HOLD:
  - instr_valid=1; instr and pc_out are held stable until dec_ready=1.
  - On acceptance, the next PC is selected by priority: jump -> jump_target; else branch&&zflag -> br_target; else pc+4.
  - The add is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
  - If the next PC has bits[1:0]!=0 -> FAULT with cause=2 and pc unchanged.
  - Otherwise pc<=next PC and instr_valid drops in the next cycle. Next state is REQ if run=1, else IDLE.
- Redirect inputs are ignored outside HOLD&&dec_ready. imem_valid outside WAIT is ignored.
- run deasserted mid-fetch: the outstanding fetch completes and is delivered, then the block goes to IDLE. pc is kept, so a later run resumes at the next PC.
- FAULT: fault=1, instr_valid=0, no requests. Exit only by rst.
- Minimum throughput: 3 cycles per instruction (REQ, WAIT with immediate valid, HOLD with dec_ready=1).
- Reset mid-WAIT: a late imem_valid arrives while in IDLE and is ignored.

Optional Feature:
FETCH_PERF_EN:
- Defined: adds outputs perf_fetches (32) and perf_stalls (32).
  - perf_fetches counts accepted instructions.
  - perf_stalls counts cycles spent in WAIT plus HOLD cycles with dec_ready=0.
  - Both saturate at 32'hFFFF_FFFF and are cleared by rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- fetch_pkg: state enum fetch_state_t, fault cause enum fault_cause_t (NONE/TIMEOUT/MISALIGN), INSTR_BYTES=4.
- Sub-module fetch_next_pc (combinational): priority next-PC select plus alignment check, outputs next_pc and misaligned.

Test Plan:
1. Straight-line: rst, run=1, memory returns rdata=addr^32'hA5A5_A5A5 one cycle after req, dec_ready=1 -> pc_out sequence 0,4,8,12; instr_valid every 3rd cycle.
2. Branch: at pc=8, branch=1, zflag=1, br_target=32'h40 -> next imem_addr=32'h40. Repeat with zflag=0 -> 32'hC. With jump=1 as well, jump_target=32'h80 wins.
3. Backpressure: dec_ready=0 for 5 cycles in HOLD -> instr/pc_out stable and no imem_req. Accept on cycle 6 -> req follows one cycle later.
4. Timeout, MAX_WAIT=15: never assert imem_valid -> fault=1, fault_cause=1 exactly 15 cycles after entering WAIT. Valid on the 15th WAIT cycle -> no fault.
5. Misaligned: jump_target=32'h42 -> fault=1, cause=2, pc_out remains at the jumping instruction. Only rst clears it.
6. Async reset asserted mid-WAIT, then deasserted: outputs return to reset values immediately; a late imem_valid is ignored; the next fetch address is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
//
// Purpose: FSM state encoding, fault cause encoding and the instruction size
//          used for sequential PC advance.
// Ports:   none (package).
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FAULT = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_TIMEOUT  = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } fault_cause_t;

  localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_sequencer_if.sv
// rtl/fetch_sequencer_if.sv - signal bundle between the fetch sequencer and its environment
//
// Purpose: groups the imem request/response, decode handshake, redirect and
//          fault signals. master = fetch_sequencer, slave = memory/decode side.
// Optional macro: FETCH_PERF_EN adds perf_fetches / perf_stalls.
// Signals:
//   run                         fetch enable
//   imem_req/imem_addr          request pulse and address
//   imem_valid/imem_rdata       response
//   instr_valid/instr/pc_out    fetched instruction to decode
//   dec_ready                   decode accept
//   jump/jump_target            unconditional redirect
//   branch/zflag/br_target      conditional redirect (taken when branch && zflag)
//   fault/fault_cause           sticky fault and its cause
interface fetch_sequencer_if #(
  parameter int XLEN = 32
);

  logic            run;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_out;
  logic            dec_ready;
  logic            jump;
  logic [XLEN-1:0] jump_target;
  logic            branch;
  logic            zflag;
  logic [XLEN-1:0] br_target;
  logic            fault;
  logic [1:0]      fault_cause;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetches;
  logic [31:0]     perf_stalls;
`endif

  modport master (
    input  run, imem_valid, imem_rdata, dec_ready,
           jump, jump_target, branch, zflag, br_target,
`ifdef FETCH_PERF_EN
    output perf_fetches, perf_stalls,
`endif
    output imem_req, imem_addr, instr_valid, instr, pc_out, fault, fault_cause
  );

  modport slave (
    output run, imem_valid, imem_rdata, dec_ready,
           jump, jump_target, branch, zflag, br_target,
`ifdef FETCH_PERF_EN
    input  perf_fetches, perf_stalls,
`endif
    input  imem_req, imem_addr, instr_valid, instr, pc_out, fault, fault_cause
  );

endinterface

// File: rtl/fetch_next_pc.sv
// rtl/fetch_next_pc.sv - combinational next-PC select with alignment check
//
// Purpose: priority select jump > taken branch > pc+4 (modulo 2^XLEN) and
//          flag a target whose low two bits are non-zero.
// Ports:
//   pc          in   current PC
//   jump        in   unconditional redirect request
//   jump_target in   absolute jump target
//   branch      in   conditional branch request
//   zflag       in   ALU zero flag
//   br_target   in   absolute branch target
//   next_pc     out  selected next PC
//   misaligned  out  next_pc[1:0] != 0
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch,
  input  logic            zflag,
  input  logic [XLEN-1:0] br_target,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc + XLEN'(INSTR_BYTES);
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && zflag) begin
      next_pc = br_target;
    end
    misaligned = |next_pc[1:0];
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer (top)
//
// Purpose: owns the PC, issues one imem request at a time, waits up to
//          MAX_WAIT cycles for the response, holds the word for decode until
//          accepted, then applies redirects. Timeout or misaligned target
//          enters a sticky FAULT state left only by rst.
// Optional macro: FETCH_PERF_EN adds saturating perf_fetches / perf_stalls.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  fetch_sequencer_if.master (see interface file for signal list)
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_sequencer_if.master  bus
);

  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  fetch_state_t    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_out_q;
  logic [31:0]     instr_q;
  logic            instr_valid_q;
  logic            fault_q;
  fault_cause_t    cause_q;
  logic [WCW-1:0]  wait_cnt;

  logic [XLEN-1:0] next_pc;
  logic            misaligned;

  fetch_next_pc #(.XLEN(XLEN)) u_next_pc (
    .pc          (pc),
    .jump        (bus.jump),
    .jump_target (bus.jump_target),
    .branch      (bus.branch),
    .zflag       (bus.zflag),
    .br_target   (bus.br_target),
    .next_pc     (next_pc),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      pc_out_q      <= RESET_PC;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= CAUSE_NONE;
      wait_cnt      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.run) state <= ST_REQ;
        end
        ST_REQ: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          // A response on the last permitted cycle takes priority over timeout.
          if (bus.imem_valid) begin
            instr_q       <= bus.imem_rdata;
            pc_out_q      <= pc;
            instr_valid_q <= 1'b1;
            state         <= ST_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            fault_q <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
            state   <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.dec_ready) begin
            instr_valid_q <= 1'b0;
            if (misaligned) begin
              // pc stays at the offending instruction for debug.
              fault_q <= 1'b1;
              cause_q <= CAUSE_MISALIGN;
              state   <= ST_FAULT;
            end else begin
              pc    <= next_pc;
              state <= bus.run ? ST_REQ : ST_IDLE;
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.imem_req    = (state == ST_REQ);
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = cause_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches_q;
  logic [31:0] perf_stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (state == ST_HOLD && bus.dec_ready && perf_fetches_q != 32'hFFFF_FFFF)
        perf_fetches_q <= perf_fetches_q + 32'd1;
      if ((state == ST_WAIT || (state == ST_HOLD && !bus.dec_ready)) &&
          perf_stalls_q != 32'hFFFF_FFFF)
        perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign bus.perf_fetches = perf_fetches_q;
  assign bus.perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  fetch_sequencer_if #(.XLEN(32)) bus ();

  fetch_sequencer #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered with the DUT in REQ; leaves it in the first HOLD cycle.
  task automatic deliver(input string tag, input logic [31:0] addr);
    chk({tag, " req"}, 64'(bus.imem_req), 64'd1);
    chk({tag, " addr"}, 64'(bus.imem_addr), 64'(addr));
    cyc();
    chk({tag, " wait no req"}, 64'(bus.imem_req), 64'd0);
    chk({tag, " wait no valid"}, 64'(bus.instr_valid), 64'd0);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = addr ^ 32'hA5A5_A5A5;
    cyc();
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    chk({tag, " instr_valid"}, 64'(bus.instr_valid), 64'd1);
    chk({tag, " instr"}, 64'(bus.instr), 64'(addr ^ 32'hA5A5_A5A5));
    chk({tag, " pc_out"}, 64'(bus.pc_out), 64'(addr));
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.dec_ready = 1'b0;
    bus.jump = 1'b0;
    bus.jump_target = 32'h0;
    bus.branch = 1'b0;
    bus.zflag = 1'b0;
    bus.br_target = 32'h0;

    // Reset state
    cyc();
    cyc();
    chk("rst imem_req", 64'(bus.imem_req), 64'd0);
    chk("rst imem_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst instr_valid", 64'(bus.instr_valid), 64'd0);
    chk("rst instr", 64'(bus.instr), 64'd0);
    chk("rst pc_out", 64'(bus.pc_out), 64'd0);
    chk("rst fault", 64'(bus.fault), 64'd0);
    chk("rst cause", 64'(bus.fault_cause), 64'd0);
    rst = 1'b0;
    cyc();
    chk("idle no req", 64'(bus.imem_req), 64'd0);

    // 1. Straight-line fetch, 3 cycles per instruction
    bus.run = 1'b1;
    bus.dec_ready = 1'b1;
    cyc();
    deliver("seq0", 32'h0);
    cyc();
    chk("seq0 drop valid", 64'(bus.instr_valid), 64'd0);
    deliver("seq4", 32'h4);
    cyc();
    deliver("seq8", 32'h8);

    // 2. Branch taken at pc=8
    bus.branch = 1'b1;
    bus.zflag = 1'b1;
    bus.br_target = 32'h40;
    cyc();
    bus.branch = 1'b0;
    bus.zflag = 1'b0;
    deliver("br40", 32'h40);
    bus.jump = 1'b1;
    bus.jump_target = 32'h8;
    cyc();
    bus.jump = 1'b0;
    deliver("jmp8", 32'h8);
    // branch not taken (zflag=0)
    bus.branch = 1'b1;
    bus.zflag = 1'b0;
    bus.br_target = 32'h40;
    cyc();
    bus.branch = 1'b0;
    deliver("brnt_c", 32'hC);
    // jump wins over taken branch
    bus.jump = 1'b1;
    bus.jump_target = 32'h80;
    bus.branch = 1'b1;
    bus.zflag = 1'b1;
    bus.br_target = 32'h40;
    bus.dec_ready = 1'b1;
    cyc();
    bus.jump = 1'b0;
    bus.branch = 1'b0;
    bus.zflag = 1'b0;

    // 3. Backpressure: dec_ready low for 5 HOLD cycles
    bus.dec_ready = 1'b0;
    deliver("bp80", 32'h80);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("bp valid", 64'(bus.instr_valid), 64'd1);
      chk("bp instr", 64'(bus.instr), 64'(32'h80 ^ 32'hA5A5_A5A5));
      chk("bp pc_out", 64'(bus.pc_out), 64'h80);
      chk("bp no req", 64'(bus.imem_req), 64'd0);
    end
    bus.dec_ready = 1'b1;
    cyc();
    chk("bp req after accept", 64'(bus.imem_req), 64'd1);
    chk("bp next addr", 64'(bus.imem_addr), 64'h84);

    // 4a. Response on the 15th WAIT cycle beats the timeout
    cyc();
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk("late no fault", 64'(bus.fault), 64'd0);
    end
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    cyc();
    bus.imem_valid = 1'b0;
    chk("late fault", 64'(bus.fault), 64'd0);
    chk("late valid", 64'(bus.instr_valid), 64'd1);
    chk("late instr", 64'(bus.instr), 64'h1234_5678);
    chk("late pc_out", 64'(bus.pc_out), 64'h84);
    cyc();
    chk("late next addr", 64'(bus.imem_addr), 64'h88);

    // 4b. No response: fault exactly 15 cycles after entering WAIT
    cyc();
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk("to pre fault", 64'(bus.fault), 64'd0);
    end
    cyc();
    chk("to fault", 64'(bus.fault), 64'd1);
    chk("to cause", 64'(bus.fault_cause), 64'd1);
    chk("to no valid", 64'(bus.instr_valid), 64'd0);
    bus.imem_valid = 1'b1;
    cyc();
    cyc();
    bus.imem_valid = 1'b0;
    chk("to sticky", 64'(bus.fault), 64'd1);
    chk("to no req", 64'(bus.imem_req), 64'd0);
    chk("to no late valid", 64'(bus.instr_valid), 64'd0);

    // 5. Misaligned jump target
    rst = 1'b1;
    #1;
    chk("rst2 fault", 64'(bus.fault), 64'd0);
    chk("rst2 cause", 64'(bus.fault_cause), 64'd0);
    chk("rst2 addr", 64'(bus.imem_addr), 64'd0);
    cyc();
    rst = 1'b0;
    cyc();
    deliver("mis0", 32'h0);
    bus.jump = 1'b1;
    bus.jump_target = 32'h42;
    cyc();
    bus.jump = 1'b0;
    chk("mis fault", 64'(bus.fault), 64'd1);
    chk("mis cause", 64'(bus.fault_cause), 64'd2);
    chk("mis pc_out", 64'(bus.pc_out), 64'd0);
    chk("mis pc kept", 64'(bus.imem_addr), 64'd0);
    chk("mis no valid", 64'(bus.instr_valid), 64'd0);
    cyc();
    cyc();
    chk("mis sticky", 64'(bus.fault), 64'd1);
    chk("mis no req", 64'(bus.imem_req), 64'd0);

    // run dropped mid-fetch: fetch completes, then IDLE, resume at next PC
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    deliver("run0", 32'h0);
    cyc();
    chk("run req4", 64'(bus.imem_req), 64'd1);
    cyc();
    bus.run = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'h4 ^ 32'hA5A5_A5A5;
    cyc();
    bus.imem_valid = 1'b0;
    chk("run off delivered", 64'(bus.instr_valid), 64'd1);
    chk("run off pc_out", 64'(bus.pc_out), 64'h4);
    cyc();
    chk("run off idle valid", 64'(bus.instr_valid), 64'd0);
    cyc();
    chk("run off no req", 64'(bus.imem_req), 64'd0);
    chk("run off pc kept", 64'(bus.imem_addr), 64'h8);
    bus.run = 1'b1;
    cyc();

    // 6. Async reset mid-WAIT
    deliver("resume8", 32'h8);
    cyc();
    cyc();
    chk("pre rst in wait", 64'(bus.imem_addr), 64'hC);
    rst = 1'b1;
    #1;
    chk("async addr", 64'(bus.imem_addr), 64'd0);
    chk("async pc_out", 64'(bus.pc_out), 64'd0);
    chk("async instr", 64'(bus.instr), 64'd0);
    chk("async valid", 64'(bus.instr_valid), 64'd0);
    bus.run = 1'b0;
    cyc();
    rst = 1'b0;
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    cyc();
    cyc();
    bus.imem_valid = 1'b0;
    chk("late ignored valid", 64'(bus.instr_valid), 64'd0);
    chk("late ignored instr", 64'(bus.instr), 64'd0);
    chk("late ignored req", 64'(bus.imem_req), 64'd0);
    bus.run = 1'b1;
    cyc();
    deliver("after rst", 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
